// File: rtl/exe_stage_pkg.sv
// Shared encodings for the cqu_mips execute stage: operation classes, subtypes,
// divider states and the ID/EX latch layout.
package exe_stage_pkg;

  localparam logic [7:0] SEL_NOP    = 8'h00;
  localparam logic [7:0] SEL_LOGIC  = 8'h01;
  localparam logic [7:0] SEL_SHIFT  = 8'h02;
  localparam logic [7:0] SEL_ARITH  = 8'h04;
  localparam logic [7:0] SEL_MOVE   = 8'h08;
  localparam logic [7:0] SEL_MULDIV = 8'h10;
  localparam logic [7:0] SEL_LDST   = 8'h20;
  localparam logic [7:0] SEL_JUMP   = 8'h40;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_LUI  = 3'd4;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDU = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBU = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_SLTU = 3'd5;

  localparam logic [2:0] OP_MFHI = 3'd0;
  localparam logic [2:0] OP_MFLO = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [2:0]  aluop;
    logic [7:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
  } idex_t;

  function automatic logic is_div_op(input logic [7:0] sel, input logic [2:0] op);
    return (sel == SEL_MULDIV) && ((op == OP_DIV) || (op == OP_DIVU));
  endfunction

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs restored on the way out. Exposes its FSM state for the stall logic.
module exe_div
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output div_state_t  state,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvs_q;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [31:0]      dvd_mag;
  logic [31:0]      dvs_mag;
  logic [32:0]      shifted;
  logic [32:0]      trial;

  assign dvd_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign dvs_mag = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // The next dividend bit enters the partial remainder from the quotient register's MSB.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (abort) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            neg_q <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r <= is_signed && dividend[31];
            quo_q <= dvd_mag;
            dvs_q <= dvs_mag;
            cnt   <= '0;
            if (divisor == 32'd0) begin
              div_zero <= 1'b1;
              rem_q    <= dividend;
              state    <= DIV_DONE;
            end else begin
              div_zero <= 1'b0;
              rem_q    <= '0;
              state    <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (trial[32]) begin
            rem_q <= shifted[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end else begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo_q + 32'd1) : quo_q);
  assign remainder = div_zero ? rem_q : (neg_r ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EX latch, ALU/shift/move/jump-link results, HI/LO with
// single-cycle multiply and an iterative divider that stalls the pipeline.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [2:0]  aluop_i,
  input  logic [7:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] imm_extend_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] pc_i,
  input  logic        alu_src_i,
  input  logic        reg_dst_i,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        ovf_o,
  output logic        stallreq_o
);

  idex_t       ex;
  idex_t       id_in;
  logic [31:0] hi_q, lo_q;
  logic [31:0] op_b, sum, dif;
  logic        ovf_add, ovf_sub;
  logic [4:0]  shamt;
  logic        wr_en, ovf;
  logic [63:0] mul_a, mul_b, prod;
  logic        is_div, div_start, div_done;
  logic [31:0] div_quo, div_rem;
  div_state_t  div_state;
  logic        stall_unused;

  assign stall_unused = ^{stall[5:4], stall[1:0]};

  always_comb begin
    id_in            = '0;
    id_in.aluop      = aluop_i;
    id_in.alusel     = alusel_i;
    id_in.reg1       = reg1_i;
    id_in.reg2       = reg2_i;
    id_in.imm        = imm_extend_i;
    id_in.rt         = rt_i;
    id_in.rd         = rd_i;
    id_in.pc         = pc_i;
    id_in.alu_src    = alu_src_i;
    id_in.reg_dst    = reg_dst_i;
    id_in.reg_write  = reg_write_i;
    id_in.mem_write  = mem_write_i;
    id_in.mem_to_reg = mem_to_reg_i;
  end

  // ID stalled while EX runs on: EX must receive a bubble, not a duplicate.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                       ex <= '0;
    else if (flush)                 ex <= '0;
    else if (stall[2] && !stall[3]) ex <= '0;
    else if (!stall[2])             ex <= id_in;
  end

  assign op_b    = ex.alu_src ? ex.imm : ex.reg2;
  assign sum     = ex.reg1 + op_b;
  assign dif     = ex.reg1 - op_b;
  assign ovf_add = (ex.reg1[31] == op_b[31]) && (sum[31] != ex.reg1[31]);
  assign ovf_sub = (ex.reg1[31] != op_b[31]) && (dif[31] != ex.reg1[31]);
  assign shamt   = ex.imm[10:6];

  always_comb begin
    wdata_o = '0;
    wr_en   = 1'b0;
    ovf     = 1'b0;
    case (ex.alusel)
      SEL_LOGIC: begin
        wr_en = ex.reg_write;
        case (ex.aluop)
          OP_AND:  wdata_o = ex.reg1 & op_b;
          OP_OR:   wdata_o = ex.reg1 | op_b;
          OP_XOR:  wdata_o = ex.reg1 ^ op_b;
          OP_NOR:  wdata_o = ~(ex.reg1 | op_b);
          OP_LUI:  wdata_o = {op_b[15:0], 16'd0};
          default: wdata_o = '0;
        endcase
      end
      SEL_SHIFT: begin
        wr_en = ex.reg_write;
        case (ex.aluop)
          OP_SLL:  wdata_o = ex.reg2 << shamt;
          OP_SRL:  wdata_o = ex.reg2 >> shamt;
          OP_SRA:  wdata_o = 32'($signed(ex.reg2) >>> shamt);
          default: wdata_o = '0;
        endcase
      end
      SEL_ARITH: begin
        wr_en = ex.reg_write;
        case (ex.aluop)
          OP_ADD:  begin wdata_o = sum; ovf = ovf_add; end
          OP_ADDU: wdata_o = sum;
          OP_SUB:  begin wdata_o = dif; ovf = ovf_sub; end
          OP_SUBU: wdata_o = dif;
          OP_SLT:  wdata_o = {31'd0, $signed(ex.reg1) < $signed(op_b)};
          OP_SLTU: wdata_o = {31'd0, ex.reg1 < op_b};
          default: wdata_o = '0;
        endcase
      end
      SEL_MOVE: begin
        case (ex.aluop)
          OP_MFHI: begin wdata_o = hi_q; wr_en = ex.reg_write; end
          OP_MFLO: begin wdata_o = lo_q; wr_en = ex.reg_write; end
          default: wr_en = 1'b0;
        endcase
      end
      SEL_LDST:  wr_en = ex.reg_write;
      SEL_JUMP: begin
        wdata_o = ex.pc + 32'd8;
        wr_en   = ex.reg_write;
      end
      SEL_NOP, SEL_MULDIV: wr_en = 1'b0;
      default:             wr_en = 1'b0;
    endcase
  end

  assign wreg_o       = wr_en && !ovf;
  assign ovf_o        = ovf;
  assign waddr_o      = ex.reg_dst ? ex.rd : ex.rt;
  assign mem_addr_o   = ex.reg1 + ex.imm;
  assign mem_wdata_o  = ex.reg2;
  assign mem_write_o  = ex.mem_write;
  assign mem_to_reg_o = ex.mem_to_reg;

  assign mul_a = (ex.aluop == OP_MULT) ? {{32{ex.reg1[31]}}, ex.reg1} : {32'd0, ex.reg1};
  assign mul_b = (ex.aluop == OP_MULT) ? {{32{ex.reg2[31]}}, ex.reg2} : {32'd0, ex.reg2};
  assign prod  = mul_a * mul_b;

  assign is_div     = is_div_op(ex.alusel, ex.aluop);
  assign div_start  = (div_state == DIV_IDLE) && is_div && !flush;
  assign stallreq_o = ((div_state == DIV_IDLE) && is_div) || (div_state == DIV_RUN);

  exe_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_start),
    .abort     (flush),
    .is_signed (ex.aluop == OP_DIV),
    .dividend  (ex.reg1),
    .divisor   (ex.reg2),
    .state     (div_state),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // HI/LO commit at the edge the EX instruction retires, so the next one sees it.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush) begin
      if (div_done) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end else if (!stall[3]) begin
        case (ex.alusel)
          SEL_MOVE: begin
            if (ex.aluop == OP_MTHI)      hi_q <= ex.reg1;
            else if (ex.aluop == OP_MTLO) lo_q <= ex.reg1;
          end
          SEL_MULDIV: begin
            if ((ex.aluop == OP_MULT) || (ex.aluop == OP_MULTU)) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus randomized instructions checked
// against an arithmetic reference model; the bench plays pipeline control.
module tb_exe_stage;

  localparam logic [7:0] C_LOGIC = 8'h01, C_SHIFT = 8'h02, C_ARITH = 8'h04, C_MOVE = 8'h08;
  localparam logic [7:0] C_MULDIV = 8'h10, C_LDST = 8'h20, C_JUMP = 8'h40;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [5:0]  stall;
  logic [5:0]  stall_drv = '0;
  logic        flush = 1'b0;
  logic [2:0]  aluop_i;
  logic [7:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i, imm_extend_i, pc_i;
  logic [4:0]  rt_i, rd_i;
  logic        alu_src_i, reg_dst_i, reg_write_i, mem_write_i, mem_to_reg_i;
  logic [31:0] wdata_o, mem_addr_o, mem_wdata_o, hi_o, lo_o;
  logic [4:0]  waddr_o;
  logic        wreg_o, mem_write_o, mem_to_reg_o, ovf_o, stallreq_o;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  exe_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .imm_extend_i(imm_extend_i), .rt_i(rt_i), .rd_i(rd_i), .pc_i(pc_i),
    .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .wdata_o(wdata_o), .waddr_o(waddr_o), .wreg_o(wreg_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .hi_o(hi_o), .lo_o(lo_o), .ovf_o(ovf_o), .stallreq_o(stallreq_o)
  );

  // Clock / reset block; pipeline control freezes ID and EX while EX asks for it.
  always #5 clk = ~clk;
  assign stall = stallreq_o ? 6'b001111 : stall_drv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic [7:0] sel, input logic [2:0] op,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                       input logic src, input logic dst, input logic rw,
                       input logic mw, input logic m2r);
    alusel_i = sel; aluop_i = op; reg1_i = r1; reg2_i = r2; imm_extend_i = imm;
    rt_i = rt; rd_i = rd; pc_i = pc; alu_src_i = src; reg_dst_i = dst;
    reg_write_i = rw; mem_write_i = mw; mem_to_reg_i = m2r;
  endtask

  task automatic drive_nop();
    drive(8'h00, 3'd0, '0, '0, '0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [7:0] sel, input logic [2:0] op,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                       input logic src, input logic dst, input logic rw,
                       input logic mw, input logic m2r);
    drive(sel, op, r1, r2, imm, rt, rd, pc, src, dst, rw, mw, m2r);
    @(posedge clk); #1;
    drive_nop();
  endtask

  // Issues a divide and counts the cycles stallreq_o stays high; returns just after
  // the edge that leaves DONE.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
    issue(C_MULDIV, sgn ? 3'd2 : 3'd3, a, b, '0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles = 0;
    @(negedge clk);
    while (stallreq_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Reference model: results straight from the instruction semantics.
  function automatic void model(input logic [7:0] sel, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] r2,
                                input logic [31:0] imm, input logic src,
                                input logic [31:0] pc, input logic rw,
                                output logic [31:0] wd, output logic wr, output logic ov);
    logic [31:0] b;
    longint      sa, sb, s;
    int          sh;
    b = src ? imm : r2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(imm[10:6]);
    wd = '0; wr = 1'b0; ov = 1'b0;
    case (sel)
      C_LOGIC: begin
        wr = rw;
        case (op)
          3'd0: wd = a & b;
          3'd1: wd = a | b;
          3'd2: wd = a ^ b;
          3'd3: wd = ~(a | b);
          3'd4: wd = b << 16;
          default: wd = '0;
        endcase
      end
      C_SHIFT: begin
        wr = rw;
        case (op)
          3'd0: wd = r2 << sh;
          3'd1: wd = r2 >> sh;
          3'd2: wd = $signed(r2) >>> sh;
          default: wd = '0;
        endcase
      end
      C_ARITH: begin
        case (op)
          3'd0, 3'd1: begin s = sa + sb; wd = a + b; ov = (op == 3'd0) && (s > 64'sd2147483647 || s < -64'sd2147483648); end
          3'd2, 3'd3: begin s = sa - sb; wd = a - b; ov = (op == 3'd2) && (s > 64'sd2147483647 || s < -64'sd2147483648); end
          3'd4: wd = (sa < sb) ? 32'd1 : 32'd0;
          3'd5: wd = (a < b) ? 32'd1 : 32'd0;
          default: wd = '0;
        endcase
        wr = rw && !ov;
      end
      C_MOVE: begin
        if (op == 3'd0) wd = m_hi;
        if (op == 3'd1) wd = m_lo;
        wr = rw && (op < 3'd2);
      end
      C_LDST: wr = rw;
      C_JUMP: begin wd = pc + 32'd8; wr = rw; end
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    drive_nop();
    @(negedge clk);
    total++;
    if ({wdata_o, waddr_o, wreg_o, mem_addr_o, mem_wdata_o, mem_write_o, mem_to_reg_o,
         hi_o, lo_o, ovf_o, stallreq_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got wdata=%h hi=%h lo=%h wreg=%b stallreq=%b, want all 0",
               wdata_o, hi_o, lo_o, wreg_o, stallreq_o);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({wdata_o, wreg_o, hi_o, lo_o, stallreq_o} !== '0) begin
      bad++;
      $display("FAIL post_reset: got wdata=%h wreg=%b hi=%h lo=%h stallreq=%b, want 0",
               wdata_o, wreg_o, hi_o, lo_o, stallreq_o);
    end
  endtask

  task automatic test_add();
    issue(C_ARITH, 3'd0, 32'd5, 32'd99, 32'd7, 5'd8, 5'd3, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (wdata_o !== 32'd12) begin bad++; $display("FAIL add_wdata: got %h want %h", wdata_o, 32'd12); end
    total++; if (waddr_o !== 5'd8) begin bad++; $display("FAIL add_waddr: got %0d want 8", waddr_o); end
    total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL add_wreg: got %b want 1", wreg_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL add_ovf: got %b want 0", ovf_o); end
  endtask

  task automatic test_overflow();
    issue(C_ARITH, 3'd0, 32'h7FFF_FFFF, 32'd1, '0, 5'd9, 5'd10, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if ({ovf_o, wreg_o} !== 2'b10) begin bad++; $display("FAIL add_ovf_flag: got ovf=%b wreg=%b want ovf=1 wreg=0", ovf_o, wreg_o); end
    issue(C_ARITH, 3'd1, 32'h7FFF_FFFF, 32'd1, '0, 5'd9, 5'd10, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (wdata_o !== 32'h8000_0000) begin bad++; $display("FAIL addu_wdata: got %h want 80000000", wdata_o); end
    total++; if ({ovf_o, wreg_o, waddr_o} !== {2'b01, 5'd10}) begin bad++; $display("FAIL addu_ctrl: got ovf=%b wreg=%b waddr=%0d want 0/1/10", ovf_o, wreg_o, waddr_o); end
    issue(C_ARITH, 3'd2, 32'h8000_0000, 32'd1, '0, 5'd9, 5'd10, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if ({ovf_o, wreg_o} !== 2'b10) begin bad++; $display("FAIL sub_ovf_flag: got ovf=%b wreg=%b want ovf=1 wreg=0", ovf_o, wreg_o); end
  endtask

  task automatic test_back_to_back();
    // MULT immediately followed by MFHI: no HI/LO bypass is needed.
    drive(C_MULDIV, 3'd0, 32'hFFFF_FFFF, 32'd2, '0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL mult_wreg: got %b want 0", wreg_o); end
    drive(C_MOVE, 3'd0, '0, '0, '0, 5'd0, 5'd4, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFE;
    total++; if (hi_o !== m_hi) begin bad++; $display("FAIL mult_hi: got %h want %h", hi_o, m_hi); end
    total++; if (lo_o !== m_lo) begin bad++; $display("FAIL mult_lo: got %h want %h", lo_o, m_lo); end
    total++; if ({wdata_o, wreg_o} !== {32'hFFFF_FFFF, 1'b1}) begin bad++; $display("FAIL mfhi_wdata: got %h wreg=%b want ffffffff wreg=1", wdata_o, wreg_o); end
  endtask

  task automatic test_div();
    int cyc;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_stall_cycles: got %0d want 33", cyc); end
    total++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin bad++; $display("FAIL div_result: got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, m_hi, m_lo); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL div_release: got stallreq=%b want 0", stallreq_o); end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_div(1'b0, 32'd7, 32'd0, cyc);
    m_hi = 32'd7; m_lo = 32'hFFFF_FFFF;
    total++; if (cyc !== 1) begin bad++; $display("FAIL divz_stall_cycles: got %0d want 1", cyc); end
    total++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin bad++; $display("FAIL divz_result: got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, m_hi, m_lo); end
  endtask

  task automatic test_div_flush();
    issue(C_MULDIV, 3'd2, 32'd100, 32'd3, '0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b want 1", stallreq_o); end
    flush = 1'b1;
    @(posedge clk); #1;
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL flush_stallreq: got %b want 0", stallreq_o); end
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if ({hi_o, lo_o, stallreq_o} !== {m_hi, m_lo, 1'b0}) begin bad++; $display("FAIL flush_hilo: got hi=%h lo=%h stallreq=%b want hi=%h lo=%h 0", hi_o, lo_o, stallreq_o, m_hi, m_lo); end
  endtask

  task automatic test_stall();
    issue(C_ARITH, 3'd0, 32'd1, 32'd2, '0, 5'd5, 5'd6, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    stall_drv = 6'b000100;
    drive(C_ARITH, 3'd0, 32'd10, 32'd20, '0, 5'd5, 5'd6, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    total++; if ({wreg_o, mem_write_o, wdata_o} !== {2'b00, 32'd0}) begin bad++; $display("FAIL stall_bubble: got wreg=%b mem_write=%b wdata=%h want 0 0 0", wreg_o, mem_write_o, wdata_o); end
    stall_drv = 6'b000000;
    @(posedge clk); #1;
    stall_drv = 6'b001100;
    drive(C_ARITH, 3'd0, 32'd100, 32'd200, '0, 5'd5, 5'd6, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if ({wdata_o, wreg_o, mem_write_o} !== {32'd30, 2'b11}) begin bad++; $display("FAIL stall_hold: got wdata=%h wreg=%b mem_write=%b want 1e 1 1", wdata_o, wreg_o, mem_write_o); end
    stall_drv = 6'b000000;
    drive_nop();
    @(posedge clk); #1;
  endtask

  task automatic test_random_alu();
    logic [7:0]  sel;
    logic [2:0]  op;
    logic [31:0] a, b, imm, pc, wd;
    logic [4:0]  rt, rd;
    logic        src, dst, rw, mw, m2r, wr, ov;
    longint      p;
    logic [63:0] pu;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: begin sel = C_LOGIC;  op = 3'($urandom_range(0, 4)); end
        1: begin sel = C_SHIFT;  op = 3'($urandom_range(0, 2)); end
        2, 3: begin sel = C_ARITH; op = 3'($urandom_range(0, 5)); end
        4: begin sel = C_MOVE;   op = 3'($urandom_range(0, 3)); end
        5: begin sel = C_MULDIV; op = 3'($urandom_range(0, 1)); end
        6: begin sel = C_LDST;   op = 3'd0; end
        7: begin sel = C_JUMP;   op = 3'd0; end
        8: begin sel = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h80; op = 3'($urandom_range(0, 7)); end
        default: begin sel = 8'h00; op = 3'd0; end
      endcase
      a = rnd32(); b = rnd32(); imm = rnd32(); pc = $urandom;
      rt = 5'($urandom); rd = 5'($urandom);
      src = 1'($urandom); dst = 1'($urandom); rw = ($urandom_range(0, 3) != 0);
      mw = 1'($urandom); m2r = 1'($urandom);
      model(sel, op, a, b, imm, src, pc, rw, wd, wr, ov);
      issue(sel, op, a, b, imm, rt, rd, pc, src, dst, rw, mw, m2r);
      total++; if (wdata_o !== wd) begin bad++; $display("FAIL rnd_wdata[%0d] sel=%h op=%0d: got %h want %h", i, sel, op, wdata_o, wd); end
      total++; if ({wreg_o, ovf_o} !== {wr, ov}) begin bad++; $display("FAIL rnd_wreg_ovf[%0d] sel=%h op=%0d: got %b%b want %b%b", i, sel, op, wreg_o, ovf_o, wr, ov); end
      total++; if (waddr_o !== (dst ? rd : rt)) begin bad++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", i, waddr_o, dst ? rd : rt); end
      total++; if ({mem_addr_o, mem_wdata_o, mem_write_o, mem_to_reg_o} !== {a + imm, b, mw, m2r}) begin bad++; $display("FAIL rnd_mem[%0d]: got addr=%h wdata=%h we=%b m2r=%b want %h %h %b %b", i, mem_addr_o, mem_wdata_o, mem_write_o, mem_to_reg_o, a + imm, b, mw, m2r); end
      if (sel == C_MULDIV && op == 3'd0) begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end else if (sel == C_MULDIV && op == 3'd1) begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end else if (sel == C_MOVE && op == 3'd2) m_hi = a;
      else if (sel == C_MOVE && op == 3'd3) m_lo = a;
      @(posedge clk); #1;
      total++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin bad++; $display("FAIL rnd_hilo[%0d] sel=%h op=%0d: got %h_%h want %h_%h", i, sel, op, hi_o, lo_o, m_hi, m_lo); end
    end
  endtask

  task automatic test_random_div();
    logic [31:0] a, b;
    logic        sgn;
    longint      q, r;
    int          cyc;
    for (int i = 0; i < 8; i++) begin
      a = rnd32();
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = rnd32();
      endcase
      sgn = 1'($urandom);
      if (b == 32'd0) begin
        m_hi = a; m_lo = 32'hFFFF_FFFF;
      end else if (sgn) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_hi = r[31:0]; m_lo = q[31:0];
      end else begin
        m_hi = a % b; m_lo = a / b;
      end
      run_div(sgn, a, b, cyc);
      total++; if (cyc !== ((b == 32'd0) ? 1 : 33)) begin bad++; $display("FAIL rdiv_cycles[%0d]: got %0d want %0d", i, cyc, (b == 32'd0) ? 1 : 33); end
      total++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin bad++; $display("FAIL rdiv_result[%0d] %h/%h s=%b: got hi=%h lo=%h want hi=%h lo=%h", i, a, b, sgn, hi_o, lo_o, m_hi, m_lo); end
    end
  endtask

  initial begin
    drive_nop();
    repeat (3) @(posedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_div_flush();
    test_stall();
    test_random_alu();
    test_random_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
